// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the memory stage: instruction codes, status
// codes, the "no register" id, the M and W pipeline-register bundles with
// their bubble values, and helpers classifying memory instructions.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;  // also cmovXX
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic        valid;
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } m_reg_t;

  typedef struct packed {
    logic        valid;
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } w_reg_t;

  localparam m_reg_t M_BUBBLE = '{valid: 1'b0, stat: STAT_AOK, icode: I_NOP,
                                  val_e: 64'd0, val_a: 64'd0,
                                  dst_e: RNONE, dst_m: RNONE};
  localparam w_reg_t W_BUBBLE = '{valid: 1'b0, stat: STAT_AOK, icode: I_NOP,
                                  val_e: 64'd0, val_m: 64'd0,
                                  dst_e: RNONE, dst_m: RNONE};

  function automatic logic is_mem_rd(input logic [3:0] icode);
    return (icode == I_MRMOVQ) || (icode == I_RET) || (icode == I_POPQ);
  endfunction

  function automatic logic is_mem_wr(input logic [3:0] icode);
    return (icode == I_RMMOVQ) || (icode == I_CALL) || (icode == I_PUSHQ);
  endfunction

  // ret/popq address the old stack pointer carried in valA
  function automatic logic addr_from_val_a(input logic [3:0] icode);
    return (icode == I_RET) || (icode == I_POPQ);
  endfunction

endpackage

// File: rtl/dmem.sv
// Byte-addressed data memory with one 64-bit little-endian read port
// (combinational) and one 64-bit write port (commits on clk). Any alignment.
//   clk      : clock
//   addr     : byte address shared by read and write
//   we       : write enable (caller must only assert when in_range)
//   wdata    : 8 bytes to store, byte 0 at addr
//   rdata    : 8 bytes read from addr
//   in_range : addr..addr+7 all inside the array
module dmem #(
  parameter int DMEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic [63:0] addr,
  input  logic        we,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic        in_range
);
  localparam int AW = $clog2(DMEM_BYTES);

  logic [7:0]    mem [DMEM_BYTES];
  logic [AW-1:0] base;

  assign base     = addr[AW-1:0];
  assign in_range = addr <= 64'(DMEM_BYTES - 8);

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 8; i++) rdata[8*i +: 8] = mem[base + AW'(i)];
  end

  // No reset: contents survive pipeline reset.
  always_ff @(posedge clk) begin
    if (we)
      for (int i = 0; i < 8; i++) mem[base + AW'(i)] <= wdata[8*i +: 8];
  end
endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: E->M register, multi-cycle data-memory access, M->W
// register and the sticky halt flag.
//   clk, rst           : clock, synchronous active-high reset
//   e_*                : execute-stage results captured into M
//   m_bubble           : load a bubble into M (loses to an active stall)
//   m_stall            : access outstanding, upstream must hold
//   m_fwd_dstE/valE    : M-register values for decode forwarding
//   w_*                : M->W register
//   halted             : a non-AOK status reached W; cleared only by rst
module memory_stage
  import y86_pkg::*;
#(
  parameter int DMEM_BYTES = 4096,
  parameter int MEM_LAT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        e_valid,
  input  logic [2:0]  e_stat,
  input  logic [3:0]  e_icode,
  input  logic        e_cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  input  logic        m_bubble,
  output logic        m_stall,
  output logic [3:0]  m_fwd_dstE,
  output logic [63:0] m_fwd_valE,
  output logic        w_valid,
  output logic [2:0]  w_stat,
  output logic [3:0]  w_icode,
  output logic [63:0] w_valE,
  output logic [63:0] w_valM,
  output logic [3:0]  w_dstE,
  output logic [3:0]  w_dstM,
  output logic        halted
);
  m_reg_t      m_q;
  w_reg_t      w_q, w_next;
  logic [3:0]  cnt;
  logic        halted_q;
  logic        mem_rd, mem_wr, mem_op, in_range, mem_we;
  logic [63:0] mem_addr, rdata;

  always_comb begin
    mem_rd   = m_q.valid && (m_q.stat == STAT_AOK) && is_mem_rd(m_q.icode);
    mem_wr   = m_q.valid && (m_q.stat == STAT_AOK) && is_mem_wr(m_q.icode);
    mem_op   = mem_rd || mem_wr;
    mem_addr = addr_from_val_a(m_q.icode) ? m_q.val_a : m_q.val_e;
  end

  // Out-of-range ops never stall: they leave with ADR on the next edge.
  assign m_stall = mem_op && in_range && !halted_q && (cnt != 4'(MEM_LAT - 1));
  // rst on the completion edge aborts the store.
  assign mem_we  = mem_wr && in_range && !halted_q && !m_stall && !rst;

  dmem #(.DMEM_BYTES(DMEM_BYTES)) u_dmem (
    .clk      (clk),
    .addr     (mem_addr),
    .we       (mem_we),
    .wdata    (m_q.val_a),
    .rdata    (rdata),
    .in_range (in_range)
  );

  always_comb begin
    w_next = W_BUBBLE;
    if (!halted_q && !m_stall) begin
      w_next.valid = m_q.valid;
      w_next.stat  = (mem_op && !in_range) ? STAT_ADR : m_q.stat;
      w_next.icode = m_q.icode;
      w_next.val_e = m_q.val_e;
      w_next.val_m = (mem_rd && in_range) ? rdata : 64'd0;
      w_next.dst_e = m_q.dst_e;
      w_next.dst_m = m_q.dst_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q      <= M_BUBBLE;
      w_q      <= W_BUBBLE;
      cnt      <= 4'd0;
      halted_q <= 1'b0;
    end else begin
      if (m_stall) begin
        cnt <= cnt + 4'd1;
      end else begin
        cnt <= 4'd0;
        if (m_bubble || !e_valid) begin
          m_q <= M_BUBBLE;
        end else begin
          m_q.valid <= 1'b1;
          m_q.stat  <= e_stat;
          m_q.icode <= e_icode;
          m_q.val_e <= e_valE;
          m_q.val_a <= e_valA;
          // untaken cmov writes no register
          m_q.dst_e <= (e_icode == I_RRMOVQ && !e_cnd) ? RNONE : e_dstE;
          m_q.dst_m <= e_dstM;
        end
      end
      w_q <= w_next;
      if (w_next.valid && w_next.stat != STAT_AOK) halted_q <= 1'b1;
    end
  end

  assign m_fwd_dstE = m_q.dst_e;
  assign m_fwd_valE = m_q.val_e;
  assign w_valid    = w_q.valid;
  assign w_stat     = w_q.stat;
  assign w_icode    = w_q.icode;
  assign w_valE     = w_q.val_e;
  assign w_valM     = w_q.val_m;
  assign w_dstE     = w_q.dst_e;
  assign w_dstM     = w_q.dst_m;
  assign halted     = halted_q;
endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
  localparam int DMEM = 4096;
  localparam int LAT  = 3;
  localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3;

  typedef struct packed {
    logic [3:0] icode; logic cnd; logic [63:0] val_e, val_a;
    logic [3:0] dst_e, dst_m; logic [2:0] stat;
  } ins_t;
  typedef struct packed {
    logic valid; logic [2:0] stat; logic [3:0] icode;
    logic [63:0] val_e, val_m; logic [3:0] dst_e, dst_m;
  } wobs_t;

  localparam wobs_t W_BUB = '{valid: 1'b0, stat: 3'd1, icode: 4'h1, val_e: 64'd0,
                              val_m: 64'd0, dst_e: 4'hF, dst_m: 4'hF};

  logic clk = 1'b0;
  logic rst, e_valid, e_cnd, m_bubble, m_stall, w_valid, halted;
  logic [2:0] e_stat, w_stat;
  logic [3:0] e_icode, e_dstE, e_dstM, m_fwd_dstE, w_icode, w_dstE, w_dstM;
  logic [63:0] e_valE, e_valA, m_fwd_valE, w_valE, w_valM;

  always #5 clk = ~clk;

  memory_stage #(.DMEM_BYTES(DMEM), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .e_valid(e_valid), .e_stat(e_stat), .e_icode(e_icode),
    .e_cnd(e_cnd), .e_valE(e_valE), .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM),
    .m_bubble(m_bubble), .m_stall(m_stall), .m_fwd_dstE(m_fwd_dstE),
    .m_fwd_valE(m_fwd_valE), .w_valid(w_valid), .w_stat(w_stat), .w_icode(w_icode),
    .w_valE(w_valE), .w_valM(w_valM), .w_dstE(w_dstE), .w_dstM(w_dstM), .halted(halted)
  );

  int n_cmp = 0, n_bad = 0;

  // Reference: byte array plus halt flag, applied one instruction at a time.
  logic [7:0] ref_mem [DMEM];
  bit         ref_halted = 1'b0;

  function automatic ins_t mk(input logic [3:0] ic, input logic [63:0] ve,
                              input logic [63:0] va, input logic [3:0] de,
                              input logic [3:0] dm, input logic c = 1'b1,
                              input logic [2:0] st = 3'd1);
    return '{icode: ic, cnd: c, val_e: ve, val_a: va, dst_e: de, dst_m: dm, stat: st};
  endfunction

  task automatic model(input ins_t i, output wobs_t w, output int stalls,
                       output logic [3:0] fdst);
    logic rd, wr;
    logic [63:0] a;
    fdst   = (i.icode == 4'h2 && !i.cnd) ? 4'hF : i.dst_e;
    stalls = 0;
    w      = W_BUB;
    if (ref_halted) return;
    rd = i.icode inside {4'h5, 4'h9, 4'hB};
    wr = i.icode inside {4'h4, 4'h8, 4'hA};
    a  = (i.icode inside {4'h9, 4'hB}) ? i.val_a : i.val_e;
    w  = '{valid: 1'b1, stat: i.stat, icode: i.icode, val_e: i.val_e, val_m: 64'd0,
           dst_e: fdst, dst_m: i.dst_m};
    if (i.stat != AOK) begin
      ref_halted = 1'b1;
    end else if (rd || wr) begin
      if (a > 64'(DMEM - 8)) begin
        w.stat = ADR;
        ref_halted = 1'b1;
      end else begin
        stalls = LAT - 1;
        for (int k = 0; k < 8; k++)
          if (wr) ref_mem[int'(a) + k] = i.val_a[8*k +: 8];
          else    w.val_m[8*k +: 8]   = ref_mem[int'(a) + k];
      end
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic drive(input ins_t i);
    e_valid = 1'b1; e_icode = i.icode; e_cnd = i.cnd; e_valE = i.val_e;
    e_valA = i.val_a; e_dstE = i.dst_e; e_dstM = i.dst_m; e_stat = i.stat;
  endtask

  task automatic idle;
    e_valid = 1'b0; e_icode = 4'h1; e_cnd = 1'b0; e_valE = '0; e_valA = '0;
    e_dstE = 4'hF; e_dstM = 4'hF; e_stat = AOK;
  endtask

  function automatic wobs_t w_now();
    return {w_valid, w_stat, w_icode, w_valE, w_valM, w_dstE, w_dstM};
  endfunction

  // Issue one instruction, let it drain to W; report what was observed.
  task automatic exec_one(input ins_t i, output int stalls, output wobs_t w,
                          output logic [63:0] fval, output logic [3:0] fdst,
                          output bit w_in_stall);
    drive(i);
    tick;
    fval = m_fwd_valE; fdst = m_fwd_dstE;
    idle;
    stalls = 0; w_in_stall = 1'b0;
    while (m_stall && stalls < 40) begin
      stalls++;
      tick;
      if (w_valid) w_in_stall = 1'b1;
    end
    tick;
    w = w_now();
  endtask

  task automatic test_reset;
    rst = 1'b1; m_bubble = 1'b0; idle;
    tick; tick;
    n_cmp++; if (w_now() !== W_BUB) begin n_bad++; $display("FAIL reset_w: got %h want %h", w_now(), W_BUB); end
    n_cmp++; if (m_stall !== 1'b0 || halted !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got stall=%b halted=%b want 0 0", m_stall, halted); end
    n_cmp++; if (m_fwd_dstE !== 4'hF || m_fwd_valE !== 64'd0) begin n_bad++; $display("FAIL reset_fwd: got %h/%h want f/0", m_fwd_dstE, m_fwd_valE); end
    rst = 1'b0;
  endtask

  // Run a list of instructions, checking each against the reference.
  task automatic test_program(input string name, input ins_t prog[$]);
    wobs_t w, ew; int st, est; logic [63:0] fv; logic [3:0] fd, efd; bit ws;
    foreach (prog[n]) begin
      model(prog[n], ew, est, efd);
      exec_one(prog[n], st, w, fv, fd, ws);
      n_cmp++; if (w !== ew) begin n_bad++; $display("FAIL %s_w[%0d]: got %h want %h", name, n, w, ew); end
      n_cmp++; if (st != est) begin n_bad++; $display("FAIL %s_stall[%0d]: got %0d want %0d", name, n, st, est); end
      n_cmp++; if (fd !== efd || fv !== prog[n].val_e) begin n_bad++; $display("FAIL %s_fwd[%0d]: got %h/%h want %h/%h", name, n, fd, fv, efd, prog[n].val_e); end
      n_cmp++; if (ws) begin n_bad++; $display("FAIL %s_bubble[%0d]: got w_valid during stall want none", name, n); end
    end
  endtask

  task automatic test_mrmovq;
    ins_t p[$];
    p = '{mk(4'h4, 64'h100, 64'h1122334455667788, 4'hF, 4'hF),
          mk(4'h5, 64'h100, 64'h0, 4'hF, 4'h3)};
    test_program("mrmovq", p);
    n_cmp++; if (w_valM !== 64'h1122334455667788 || w_dstM !== 4'h3 || w_valid !== 1'b1) begin n_bad++; $display("FAIL mrmovq_const: got %h/%h/%b want 1122334455667788/3/1", w_valM, w_dstM, w_valid); end
  endtask

  task automatic test_push_pop;
    ins_t p[$];
    p = '{mk(4'h4, 64'h200, 64'h0, 4'hF, 4'hF),
          mk(4'hA, 64'h1F8, 64'hDEADBEEF, 4'h4, 4'hF),
          mk(4'hB, 64'h200, 64'h1F8, 4'h4, 4'h0)};
    test_program("pushpop", p);
    n_cmp++; if (w_valM !== 64'hDEADBEEF) begin n_bad++; $display("FAIL pop_val: got %h want deadbeef", w_valM); end
    // unaligned read exposes byte order: 0x1FB holds DE, 0x1FC..0x202 zero
    p = '{mk(4'h5, 64'h1FB, 64'h0, 4'hF, 4'h1)};
    test_program("bytes", p);
    n_cmp++; if (w_valM !== 64'h00000000000000DE) begin n_bad++; $display("FAIL byte_order: got %h want de", w_valM); end
  endtask

  task automatic test_random;
    ins_t p[$]; ins_t i; logic [63:0] r;
    for (int k = 0; k <= 32; k++)
      p.push_back(mk(4'h4, 64'h400 + 64'(8*k), {$urandom, $urandom}, 4'hF, 4'hF));
    for (int k = 0; k < 40; k++) begin
      i = mk(4'($urandom_range(1, 11)), {$urandom, $urandom}, {$urandom, $urandom},
             4'($urandom), 4'($urandom), 1'($urandom));
      r = 64'h400 + 64'($urandom_range(0, 255));
      if (i.icode inside {4'h9, 4'hB}) i.val_a = r;
      else if (i.icode inside {4'h4, 4'h5, 4'h8, 4'hA}) i.val_e = r;
      p.push_back(i);
    end
    test_program("random", p);
  endtask

  task automatic test_back_to_back;
    ins_t op, mr; wobs_t eo, em; int es, n; logic [3:0] fd;
    op = mk(4'h6, {$urandom, $urandom}, 64'h5, 4'h2, 4'hF);
    mr = mk(4'h5, 64'h100, 64'h0, 4'hF, 4'h7);
    model(op, eo, es, fd);
    model(mr, em, es, fd);
    drive(op); tick;
    n_cmp++; if (m_fwd_valE !== op.val_e || m_fwd_dstE !== 4'h2 || m_stall !== 1'b0) begin n_bad++; $display("FAIL b2b_fwd: got %h/%h/%b want %h/2/0", m_fwd_valE, m_fwd_dstE, m_stall, op.val_e); end
    drive(mr); tick; idle;
    n_cmp++; if (w_now() !== eo) begin n_bad++; $display("FAIL b2b_opq: got %h want %h", w_now(), eo); end
    n = 0;
    while (m_stall && n < 40) begin n++; tick; end
    n_cmp++; if (n != LAT - 1) begin n_bad++; $display("FAIL b2b_stall: got %0d want %0d", n, LAT - 1); end
    tick;
    n_cmp++; if (w_now() !== em) begin n_bad++; $display("FAIL b2b_mrmovq: got %h want %h", w_now(), em); end
  endtask

  task automatic test_bubble_during_stall;
    ins_t mr; wobs_t em; int es, n; logic [3:0] fd;
    mr = mk(4'h5, 64'h100, 64'h0, 4'hF, 4'h5);
    model(mr, em, es, fd);
    drive(mr); tick;
    m_bubble = 1'b1;
    drive(mk(4'h6, 64'h77, 64'h0, 4'h3, 4'hF));
    n = 0;
    while (m_stall && n < 40) begin
      n_cmp++; if (m_fwd_valE !== 64'h100) begin n_bad++; $display("FAIL bub_hold: got %h want 100", m_fwd_valE); end
      n++; tick;
    end
    n_cmp++; if (n != LAT - 1) begin n_bad++; $display("FAIL bub_stall: got %0d want %0d", n, LAT - 1); end
    tick;
    n_cmp++; if (w_now() !== em) begin n_bad++; $display("FAIL bub_w: got %h want %h", w_now(), em); end
    n_cmp++; if (m_fwd_dstE !== 4'hF || m_fwd_valE !== 64'd0) begin n_bad++; $display("FAIL bub_m: got %h/%h want f/0", m_fwd_dstE, m_fwd_valE); end
    m_bubble = 1'b0; idle; tick;
    n_cmp++; if (w_valid !== 1'b0) begin n_bad++; $display("FAIL bub_drop: got w_valid=%b want 0", w_valid); end
  endtask

  task automatic test_reset_abort;
    ins_t p[$]; int n;
    p = '{mk(4'h4, 64'h40, 64'hA5A5_0000_1234_5678, 4'hF, 4'hF)};
    test_program("abort_pre", p);
    drive(mk(4'h4, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 4'hF)); tick; idle;
    n = 0;
    while (m_stall && n < 40) begin n++; tick; end
    rst = 1'b1; tick; rst = 1'b0;
    n_cmp++; if (w_now() !== W_BUB || m_stall !== 1'b0) begin n_bad++; $display("FAIL abort_w: got %h stall=%b want %h 0", w_now(), m_stall, W_BUB); end
    p = '{mk(4'h5, 64'h40, 64'h0, 4'hF, 4'h2)};
    test_program("abort_read", p);
  endtask

  task automatic test_adr_halt;
    ins_t p[$];
    p = '{mk(4'h4, 64'(DMEM - 8), 64'h0102030405060708, 4'hF, 4'hF),
          mk(4'h4, 64'h300, 64'h0BAD_F00D_CAFE_0001, 4'hF, 4'hF),
          mk(4'h4, 64'(DMEM - 7), 64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 4'hF)};
    test_program("adr", p);
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL adr_halted: got %b want 1", halted); end
    p = '{mk(4'h4, 64'h300, 64'h0, 4'hF, 4'hF)};
    test_program("halted_drop", p);
    rst = 1'b1; tick; rst = 1'b0; ref_halted = 1'b0;
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL halt_clear: got %b want 0", halted); end
    p = '{mk(4'h5, 64'(DMEM - 8), 64'h0, 4'hF, 4'h1),
          mk(4'h5, 64'h300, 64'h0, 4'hF, 4'h2),
          mk(4'h0, 64'h0, 64'h0, 4'hF, 4'hF, 1'b1, HLT)};
    test_program("after_halt", p);
    n_cmp++; if (halted !== 1'b1 || w_stat !== HLT) begin n_bad++; $display("FAIL hlt_stat: got %b/%h want 1/2", halted, w_stat); end
  endtask

  initial begin
    test_reset;
    test_mrmovq;
    test_push_pop;
    test_random;
    test_back_to_back;
    test_bubble_during_stall;
    test_reset_abort;
    test_adr_halt;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Y86-64 pipeline stage directly downstream of execute. Holds the E->M pipeline register and performs the data-memory access for rmmovq, mrmovq, call, ret, pushq and popq.
- Drives the M->W register consumed by writeback, and the M-register forwarding values consumed by decode.
- Memory has a fixed multi-cycle latency. The stage stalls the upstream pipeline while an access is outstanding.

Parameters:
- DMEM_BYTES, 4096: data memory size in bytes, byte-addressed.
- MEM_LAT, 2: cycles per memory access. Legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- e_valid  in  1  E-stage output holds a real instruction
- e_stat  in  3  status from execute (AOK=1, HLT=2, ADR=3, INS=4)
- e_icode  in  4  instruction code
- e_cnd  in  1  condition result from execute
- e_valE  in  64  ALU result / effective address
- e_valA  in  64  store data or pop/ret stack pointer
- e_dstE  in  4  register destination for valE (4'hF = none)
- e_dstM  in  4  register destination for valM (4'hF = none)
- m_bubble  in  1  pipeline control: load a bubble into M
- m_stall  out  1  memory access outstanding; upstream must hold
- m_fwd_dstE  out  4  M-register dstE, for forwarding
- m_fwd_valE  out  64  M-register valE, for forwarding
- w_valid, w_stat, w_icode, w_valE, w_valM, w_dstE, w_dstM  out  1/3/4/64/64/4/4  M->W register
- halted  out  1  sticky: a non-AOK status has reached W

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - M and W registers load a bubble: valid=0, icode=1 (nop), stat=AOK, dstE=dstM=4'hF, valE=valM=0.
  - Access counter cleared; halted=0.
  - Memory contents are unaffected.
  - Reset on the same edge an access would complete aborts it: no write, W gets a bubble.
- Memory-op decode from the M register (op applies only if M valid and M stat=AOK):
  - Read: icode 5, 9, B.
  - Write: icode 4, 8, A.
  - Address is valE for icodes 4, 5, 8, A; valA for 9, B. Write data is valA.
- Access: 8 bytes, little-endian, any alignment. Out of range if addr > DMEM_BYTES-8 (unsigned 64-bit compare).
  - Out-of-range op: no access, no stall, W gets stat=ADR in one cycle.
- Counter cnt (4 bits):
  - m_stall = mem_op && in_range && !halted && (cnt != MEM_LAT-1); combinational.
  - Each edge with m_stall=1: cnt increments, M holds, W loads a bubble.
  - Edge with m_stall=0 and a mem op pending: access performed, cnt cleared to 0.
  - Write commits on that edge; read data lands in w_valM on that edge.
  - A mem-op instruction therefore occupies M for exactly MEM_LAT cycles. MEM_LAT=1 never stalls.
- Non-memory instructions pass M->W in one cycle, w_valM=0.
- M register load priority: rst > m_stall (hold) > m_bubble (bubble) > E inputs.
  - When e_valid=0, M loads a bubble.
- W load: the M contents, with w_valM set and w_stat replaced by ADR on address error.
  - cmovXX with e_cnd=0: dstE is forced to 4'hF on capture into M.
- Halted:
  - Set on the edge W captures valid stat != AOK.
  - While set: no memory writes, m_stall=0, W loads only bubbles.
  - Cleared only by rst.
- Forwarding outputs are straight from the M register, unaffected by stall.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants (I_NOP … I_POPQ)
  - stat codes (STAT_AOK, STAT_HLT, STAT_ADR, STAT_INS)
  - RNONE=4'hF
  - a bubble-value constant for the M/W bundle
- One sub-module, dmem: byte array of DMEM_BYTES, 64-bit little-endian read port and write port, in_range output. Purely array plus bounds check; the FSM and counter stay in memory_stage.

Test Plan:
- mrmovq, MEM_LAT=2, M[0x100]=0x1122334455667788, valE=0x100, dstM=3 -> m_stall high 1 cycle, then w_valM=0x1122334455667788, w_dstM=3, w_valid=1. The bubble cycle in between has w_valid=0.
- pushq, valE=0x1F8, valA=0xDEADBEEF, followed by popq with valA=0x1F8 -> popq w_valM=0xDEADBEEF. Bytes 0x1F8..0x1FF hold EF BE AD DE 00 00 00 00.
- rmmovq, valE=DMEM_BYTES-7 -> no stall, w_stat=ADR, memory unchanged, halted=1 next cycle. A following rmmovq is dropped and W stays bubble.
- opq (icode 6) back-to-back with mrmovq, MEM_LAT=3 -> opq reaches W in 1 cycle; mrmovq stalls 2 cycles. m_fwd_valE equals the opq result while opq is in M.
- rst asserted on the completion edge of rmmovq to 0x40 -> M[0x40] unchanged, all W outputs at their bubble values, m_stall=0, cnt=0.
- m_bubble=1 while m_stall=1 -> M holds the load; the bubble is ignored until the stall clears.
